// File: rtl/filter_chain_sequencer.sv
// Per-sample sequencer for cascaded filter stages: runs the enabled stages in order over trig/end handshakes.
// Optional FCS_ERR_CNT_EN adds saturating timeout/overrun event counters.
module filter_chain_sequencer #(
   parameter int W           = 24,
   parameter int N_STAGES    = 3,
   parameter int TIMEOUT_CYC = 4096,
   parameter int CNT_W       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sample_valid,
   input  logic [W-1:0]          sample_in,
   input  logic [N_STAGES-1:0]   enable,
   input  logic                  err_clr,
   output logic [W-1:0]          stg_din,
   output logic [N_STAGES-1:0]   stg_trig,
   input  logic [N_STAGES*W-1:0] stg_dout,
   input  logic [N_STAGES-1:0]   stg_end,
   output logic [W-1:0]          out_data,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  err_timeout,
   output logic                  err_overrun
`ifdef FCS_ERR_CNT_EN
   ,
   output logic [CNT_W-1:0]      timeout_cnt,
   output logic [CNT_W-1:0]      overrun_cnt
`endif
);

   localparam int IDX_W = $clog2(N_STAGES + 1);

   typedef enum logic [2:0] {IDLE, SCAN, TRIG, WAIT, OUT} state_t;

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic [N_STAGES-1:0] en_snap;
   logic [W-1:0]        acc;
   logic [15:0]         timer;

   logic                cur_en;
   logic                cur_end;
   logic [W-1:0]        cur_dout;
   logic [N_STAGES-1:0] cur_hot;
   logic                overrun_ev;
   logic                timeout_ev;

   // Select the current stage's enable, end pulse and result by comparison so idx==N_STAGES never indexes out of range.
   always_comb begin
      cur_en   = 1'b0;
      cur_end  = 1'b0;
      cur_dout = '0;
      cur_hot  = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_en     = en_snap[i];
            cur_end    = stg_end[i];
            cur_dout   = stg_dout[i*W +: W];
            cur_hot[i] = 1'b1;
         end
      end
   end

   assign overrun_ev = sample_valid && (state == SCAN || state == TRIG || state == WAIT);
   assign timeout_ev = (state == WAIT) && !cur_end && (timer == 16'(TIMEOUT_CYC - 1));
   assign stg_din    = acc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         en_snap   <= '0;
         acc       <= '0;
         timer     <= '0;
         stg_trig  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         stg_trig  <= '0;
         out_valid <= 1'b0;
         case (state)
            IDLE, OUT: begin
               if (sample_valid) begin
                  acc     <= sample_in;
                  en_snap <= enable;
                  idx     <= '0;
                  busy    <= 1'b1;
                  state   <= SCAN;
               end else begin
                  state   <= IDLE;
               end
            end
            SCAN: begin
               if (idx == IDX_W'(N_STAGES)) begin
                  out_valid <= 1'b1;
                  out_data  <= acc;
                  busy      <= 1'b0;
                  state     <= OUT;
               end else if (!cur_en) begin
                  idx       <= idx + 1'b1;
               end else begin
                  stg_trig  <= cur_hot;
                  state     <= TRIG;
               end
            end
            TRIG: begin
               timer <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // A timed-out stage leaves acc untouched, i.e. it behaves as bypassed.
               if (cur_end) begin
                  acc   <= cur_dout;
                  idx   <= idx + 1'b1;
                  state <= SCAN;
               end else if (timeout_ev) begin
                  idx   <= idx + 1'b1;
                  state <= SCAN;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky flags: a new event in the same cycle as err_clr wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         if (timeout_ev)      err_timeout <= 1'b1;
         else if (err_clr)    err_timeout <= 1'b0;
         if (overrun_ev)      err_overrun <= 1'b1;
         else if (err_clr)    err_overrun <= 1'b0;
      end
   end

`ifdef FCS_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_cnt <= '0;
         overrun_cnt <= '0;
      end else begin
         if (err_clr)                             timeout_cnt <= timeout_ev ? CNT_W'(1) : '0;
         else if (timeout_ev && timeout_cnt != '1) timeout_cnt <= timeout_cnt + 1'b1;
         if (err_clr)                             overrun_cnt <= overrun_ev ? CNT_W'(1) : '0;
         else if (overrun_ev && overrun_cnt != '1) overrun_cnt <= overrun_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: doc/filter_chain_sequencer.md
Name: filter_chain_sequencer

Overview:
Per-sample scheduler for the cascaded audio filter stages (notch, high-pass, low-pass) between the codec wrapper and the DAC path. It accepts one sample per codec ready pulse and runs the enabled stages strictly in order over their sample_trig/filter_end handshakes. Each stage receives the previous enabled stage's result. Bypassed stages cost one cycle; hung stages are timed out. The block reports the final sample, busy and error status.

Parameters:
W, 24, sample width in bits (two's complement)
N_STAGES, 3, number of cascaded stages; stage 0 runs first
TIMEOUT_CYC, 4096, max cycles waited for a stage's end pulse, range 2..65535
CNT_W, 8, error counter width (used only with the optional feature)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
sample_valid  in  1  one-cycle pulse from the codec ready strobe
sample_in  in  W  input sample; valid with sample_valid
enable  in  N_STAGES  per-stage enable; bit i=1 runs stage i
err_clr  in  1  pulse; clears sticky flags (and counters)
stg_din  out  W  data to the active stage; shared by all stages
stg_trig  out  N_STAGES  one-hot sample_trig pulse per stage
stg_dout  in  N_STAGES*W  stage results; stage i occupies bits [i*W +: W]
stg_end  in  N_STAGES  filter_end pulse per stage
out_data  out  W  processed sample
out_valid  out  1  one-cycle pulse; out_data is valid
busy  out  1  high from sample acceptance until out_valid
err_timeout  out  1  sticky; a stage timed out
err_overrun  out  1  sticky; a sample arrived while busy and was dropped

Behaviour:
- Reset values: state IDLE; all outputs 0: stg_din, stg_trig, out_data, out_valid, busy, flags, counters. Reset mid-operation aborts immediately: no trig, no out_valid. Late stg_end pulses after reset are ignored.
- FSM states: IDLE, SCAN, TRIG, WAIT, OUT. Registers: acc (W), idx, en_snap (N_STAGES), timer (16 bit).
- Sample acceptance: in IDLE or OUT with sample_valid=1, the block sets acc<=sample_in, en_snap<=enable, idx<=0 and enters SCAN. busy goes high from the next cycle.
- enable is sampled only at acceptance; later changes do not affect the sample in flight.
- SCAN, one cycle:
  - idx==N_STAGES: go to OUT.
  - en_snap[idx]=0: idx<=idx+1, stay in SCAN.
  - en_snap[idx]=1: go to TRIG.
- TRIG, one cycle: stg_trig[idx]=1, all other trig bits 0. timer<=0. Go to WAIT.
- stg_din always equals acc and is stable from TRIG until the stage resolves.
- WAIT:
  - stg_end[idx]=1: acc<=stg_dout[idx], idx<=idx+1, go to SCAN.
  - Otherwise timer increments. At timer==TIMEOUT_CYC-1 with no end pulse: acc unchanged (stage treated as bypassed), err_timeout<=1, idx<=idx+1, go to SCAN.
  - stg_end bits for stages other than idx are ignored, as is any stg_end outside WAIT.
- OUT, one cycle: out_valid=1, out_data=acc, busy=0. Go to IDLE unless a new sample is accepted in the same cycle.
- out_data holds its value until the next OUT.
- Latency, with acceptance at edge E0:
  - All bypassed: SCAN spans E1..E4 (N_STAGES+1 SCAN cycles), out_valid is high in the cycle after E4.
  - Each enabled stage adds TRIG (1 cycle) plus its end latency in WAIT.
- Overrun: sample_valid=1 in SCAN, TRIG or WAIT drops the sample and sets err_overrun<=1. The in-flight sample is unaffected.
- err_clr clears the flags. If err_clr and a new error event occur in the same cycle, the set wins.
- Arithmetic: no arithmetic on samples; data is passed bit-exact.

Optional Feature:
FCS_ERR_CNT_EN
- Defined: adds outputs timeout_cnt[CNT_W-1:0] and overrun_cnt[CNT_W-1:0].
  - Each increments by 1 per event and saturates at all-ones.
  - err_clr clears both to 0; reset clears both to 0.
  - If err_clr and an event coincide, the result is 1.
- Undefined: the counters and ports are absent; only the sticky flags exist.

Test Plan:
- enable=000, sample_in=24'h123456 pulse at E0 → out_valid high the cycle after E4, out_data=24'h123456, no stg_trig ever asserted.
- enable=111; model stage i returns din+i+1 with end 5 cycles after trig; sample_in=24'h000010 → trig order 0,1,2; stg_din sequence 10, 11, 13; out_data=24'h000016.
- enable=010, stage 1 never pulses end, TIMEOUT_CYC=8 → err_timeout=1 after 8 WAIT cycles; out_data equals sample_in unchanged; err_clr pulse → err_timeout=0.
- enable=111 with slow stages; second sample_valid during WAIT → err_overrun=1; first sample's out_data correct; no second out_valid.
- reset asserted during WAIT of stage 1 → next cycle all outputs 0, state IDLE; subsequent stg_end[1] ignored; next sample processed normally.
- sample_valid coincident with the OUT cycle → accepted with no overrun; back-to-back out_valid pulses correct. With FCS_ERR_CNT_EN: 300 overruns at CNT_W=8 → overrun_cnt=255.
